// File: rtl/aes_pkg.sv
// Shared AES-128 types and constants for the key schedule and encryption datapath.
package aes_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned NUM_WORDS = 44;
  localparam int unsigned KEY_W     = 128;
  localparam int unsigned CNT_W     = 6;

  // Indexed by cnt[5:2]; entries outside 1..10 are never used.
  localparam logic [7:0] RCON [0:15] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } kx_state_e;

endpackage

// File: rtl/key_expansion_if.sv
// Request/response bundle between the key source, key_expansion and encryption.
interface key_expansion_if;
  import aes_pkg::*;

  logic             start;
  logic [KEY_W-1:0] key_in;
  word_t            key_schedule [0:NUM_WORDS-1];
  logic             busy;
  logic             key_ready;

  modport master (
    output start,
    output key_in,
    input  key_schedule,
    input  busy,
    input  key_ready
  );

  modport slave (
    input  start,
    input  key_in,
    output key_schedule,
    output busy,
    output key_ready
  );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box lookup, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  // Row-major table, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign data_o = SBOX_TABLE[{~data_i, 3'b000} +: 8];

endmodule

// File: rtl/key_expansion.sv
// Iterative AES-128 key expansion: one schedule word per clock, 40 cycles start to ready.
module key_expansion
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  key_expansion_if.slave    bus
);

  kx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  word_t            w_q [0:NUM_WORDS-1];

  logic             load_c;
  logic             wr_en_c;
  logic [CNT_W-1:0] prev_idx_c;
  logic [CNT_W-1:0] back_idx_c;
  word_t            prev_c;
  word_t            rot_c;
  word_t            sub_c;
  word_t            temp_c;
  word_t            next_word_c;

  // temp/XOR datapath for the word at position cnt
  assign prev_idx_c  = cnt_q - CNT_W'(1);
  assign back_idx_c  = cnt_q - CNT_W'(4);
  assign prev_c      = w_q[prev_idx_c];
  assign rot_c       = {prev_c[23:0], prev_c[31:24]};
  assign temp_c      = (cnt_q[1:0] == 2'b00) ? (sub_c ^ {RCON[cnt_q[5:2]], 24'h0}) : prev_c;
  assign next_word_c = w_q[back_idx_c] ^ temp_c;

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .data_i (rot_c[8*b +: 8]),
      .data_o (sub_c[8*b +: 8])
    );
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      if (load_c) begin
        w_q[0] <= bus.key_in[127:96];
        w_q[1] <= bus.key_in[95:64];
        w_q[2] <= bus.key_in[63:32];
        w_q[3] <= bus.key_in[31:0];
      end else if (wr_en_c) begin
        w_q[cnt_q] <= next_word_c;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    load_c  = 1'b0;
    wr_en_c = 1'b0;
    unique case (state_q)
      IDLE, READY: begin
        if (bus.start) begin
          load_c  = 1'b1;
          cnt_d   = CNT_W'(4);
          busy_d  = 1'b1;
          ready_d = 1'b0;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        wr_en_c = 1'b1;
        if (cnt_q == CNT_W'(NUM_WORDS - 1)) begin
          busy_d  = 1'b0;
          ready_d = 1'b1;
          state_d = READY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.key_schedule = w_q;
  assign bus.busy         = busy_q;
  assign bus.key_ready    = ready_q;

endmodule

// File: tb/tb_key_expansion.sv
// Directed checks of key_expansion against known AES-128 schedules.
module tb_key_expansion;
  import aes_pkg::*;

  localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_LUKE = 128'h6c756b65696d796f7572666174686572;
  localparam logic [127:0] KEY_ZERO = 128'h0;
  localparam int           NVEC     = 18;

  typedef struct {
    logic [127:0] key;
    int           idx;
    logic [31:0]  exp;
  } vec_t;

  logic clk;
  logic n_rst;
  int   checks;
  int   errors;
  vec_t vecs [NVEC];

  key_expansion_if kif ();

  key_expansion dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pulse start for one edge; returns just after the sampling edge E0.
  task automatic start_exp(input logic [127:0] key);
    @(negedge clk);
    kif.key_in = key;
    kif.start  = 1'b1;
    @(negedge clk);
    kif.start  = 1'b0;
  endtask

  // Counts edges until key_ready is seen, bounded.
  task automatic wait_ready(output int lat);
    lat = 0;
    while (lat < 80) begin
      @(negedge clk);
      lat++;
      if (kif.key_ready) break;
    end
  endtask

  // busy and key_ready must never be high together
  always @(negedge clk) begin
    if (n_rst) check("busy_ready_excl", 32'(kif.busy & kif.key_ready), 32'h0);
  end

  initial begin
    int          lat;
    logic        nonzero;
    logic [127:0] cur_key;

    checks = 0;
    errors = 0;
    vecs[0]  = '{KEY_FIPS,  0, 32'h2b7e1516};
    vecs[1]  = '{KEY_FIPS,  3, 32'h09cf4f3c};
    vecs[2]  = '{KEY_FIPS,  4, 32'ha0fafe17};
    vecs[3]  = '{KEY_FIPS,  5, 32'h88542cb1};
    vecs[4]  = '{KEY_FIPS,  6, 32'h23a33939};
    vecs[5]  = '{KEY_FIPS,  7, 32'h2a6c7605};
    vecs[6]  = '{KEY_FIPS, 40, 32'hd014f9a8};
    vecs[7]  = '{KEY_FIPS, 43, 32'hb6630ca6};
    vecs[8]  = '{KEY_LUKE,  0, 32'h6c756b65};
    vecs[9]  = '{KEY_LUKE,  3, 32'h74686572};
    vecs[10] = '{KEY_LUKE,  4, 32'h28382bf7};
    vecs[11] = '{KEY_LUKE,  8, 32'haee916fe};
    vecs[12] = '{KEY_LUKE, 40, 32'h04a2e8ef};
    vecs[13] = '{KEY_LUKE, 43, 32'ha4405979};
    vecs[14] = '{KEY_ZERO,  4, 32'h62636363};
    vecs[15] = '{KEY_ZERO,  5, 32'h62636363};
    vecs[16] = '{KEY_ZERO,  7, 32'h62636363};
    vecs[17] = '{KEY_ZERO,  8, 32'h9b9898c9};

    kif.start  = 1'b0;
    kif.key_in = '0;
    n_rst      = 1'b0;

    // start pulsed while reset is held
    repeat (2) @(negedge clk);
    kif.key_in = KEY_FIPS;
    kif.start  = 1'b1;
    repeat (2) @(negedge clk);
    kif.start  = 1'b0;
    nonzero = 1'b0;
    for (int i = 0; i < NUM_WORDS; i++) nonzero |= (kif.key_schedule[i] != 32'h0);
    check("reset_words_zero", 32'(nonzero), 32'h0);
    check("reset_busy", 32'(kif.busy), 32'h0);
    check("reset_ready", 32'(kif.key_ready), 32'h0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset_busy", 32'(kif.busy), 32'h0);

    // table-driven schedules; a new expansion whenever the key changes
    cur_key = '1;
    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].key !== cur_key) begin
        start_exp(vecs[i].key);
        check("busy_after_start", 32'(kif.busy), 32'h1);
        check("ready_after_start", 32'(kif.key_ready), 32'h0);
        wait_ready(lat);
        check("latency", 32'(lat), 32'd40);
        cur_key = vecs[i].key;
      end
      check($sformatf("w%0d_key%0d", vecs[i].idx, i), kif.key_schedule[vecs[i].idx], vecs[i].exp);
    end

    // reset asserted at cycle 20 of an expansion
    start_exp(KEY_FIPS);
    repeat (19) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("midrst_busy", 32'(kif.busy), 32'h0);
    check("midrst_ready", 32'(kif.key_ready), 32'h0);
    check("midrst_w0", kif.key_schedule[0], 32'h0);
    check("midrst_w4", kif.key_schedule[4], 32'h0);
    @(negedge clk);
    n_rst = 1'b1;
    start_exp(KEY_FIPS);
    wait_ready(lat);
    check("midrst_latency", 32'(lat), 32'd40);
    check("midrst_w4_after", kif.key_schedule[4], 32'ha0fafe17);
    check("midrst_w43_after", kif.key_schedule[43], 32'hb6630ca6);

    // second start with another key during EXPAND is ignored
    start_exp(KEY_ZERO);
    repeat (10) @(negedge clk);
    kif.key_in = KEY_LUKE;
    kif.start  = 1'b1;
    @(negedge clk);
    kif.start  = 1'b0;
    wait_ready(lat);
    check("ignore_latency", 32'(lat), 32'd29);
    check("ignore_w0", kif.key_schedule[0], 32'h00000000);
    check("ignore_w8", kif.key_schedule[8], 32'h9b9898c9);

    // from READY: FIPS then luke, key_ready drops one edge after start
    start_exp(KEY_FIPS);
    check("reready_drop", 32'(kif.key_ready), 32'h0);
    wait_ready(lat);
    check("reready_fips_w43", kif.key_schedule[43], 32'hb6630ca6);
    start_exp(KEY_LUKE);
    check("reready_drop2", 32'(kif.key_ready), 32'h0);
    check("reready_busy2", 32'(kif.busy), 32'h1);
    wait_ready(lat);
    check("reready_latency2", 32'(lat), 32'd40);
    check("reready_luke_w4", kif.key_schedule[4], 32'h28382bf7);
    check("reready_luke_w43", kif.key_schedule[43], 32'ha4405979);

    // start held high: one expansion, one-cycle key_ready, then restart
    @(negedge clk);
    kif.key_in = KEY_FIPS;
    kif.start  = 1'b1;
    @(negedge clk);
    wait_ready(lat);
    check("held_latency", 32'(lat), 32'd40);
    @(negedge clk);
    check("held_ready_pulse", 32'(kif.key_ready), 32'h0);
    check("held_restart_busy", 32'(kif.busy), 32'h1);
    kif.start = 1'b0;
    wait_ready(lat);
    check("held_latency2", 32'(lat), 32'd40);
    check("held_w43", kif.key_schedule[43], 32'hb6630ca6);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_expansion.md
# key_expansion

Iterative AES-128 key expansion for the `encryption` pipeline. It takes a 128-bit cipher key and produces the 44-word round-key schedule on the `encryption` block's `key_schedule` input, one 32-bit word per clock. It raises `key_ready` once the schedule is complete and holds the schedule stable until the next expansion request.

## Interface
Parameters:
- None. The block is fixed to AES-128: Nk = 4, Nr = 10, 44 words.

Ports:
- One clock; reset is asynchronous and active-low, on `clk` and `n_rst`.
- `clk` input 1: system clock, rising-edge active.
- `n_rst` input 1: asynchronous active-low reset.
- `start` input 1: expansion request. Single-cycle pulse or level; sampled on the rising edge.
- `key_in` input 128: cipher key. Byte 0 is in bits [127:120].
- `key_schedule` output 32 x [0:43]: round-key words w[0]..w[43]. Connects directly to `encryption.key_schedule`.
- `busy` output 1: high while expansion is in progress.
- `key_ready` output 1: high when all 44 words are valid and stable.

## Operation
- FSM has three states: IDLE, EXPAND, READY.
- IDLE:
  - `start`=1 → load w[0]=key_in[127:96], w[1]=key_in[95:64], w[2]=key_in[63:32], w[3]=key_in[31:0].
  - Set cnt=4 and go to EXPAND.
- EXPAND:
  - Each cycle, write w[cnt] = w[cnt-4] ^ temp, where temp = w[cnt-1].
  - If cnt%4 == 0: temp = SubWord(RotWord(w[cnt-1])) ^ {Rcon[cnt/4], 24'h0}.
  - RotWord({a,b,c,d}) = {b,c,d,a}. SubWord applies the AES S-box to each byte.
  - Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
  - cnt is a 6-bit counter, 4..43. After writing w[43], go to READY.
  - `start` is ignored in EXPAND.
- READY:
  - Schedule is held.
  - `start`=1 → reload w[0..3] from the new key, clear `key_ready`, go to EXPAND with cnt=4.
- `key_in` is sampled only on the start edge. Later changes to `key_in` have no effect on an expansion in progress.
- Words w[cnt+1..43] hold stale values during EXPAND. Downstream must not launch blocks until `key_ready`=1.

## Timing
- Reset values: every `key_schedule` word = 32'h0, `busy`=0, `key_ready`=0, state = IDLE, cnt = 0.
- Reset asserted mid-expansion aborts immediately and clears everything. No partial schedule survives.
- Let edge E0 be the edge that samples `start`=1. Then:
  - w[0..3] are valid after E0, and `busy`=1.
  - w[4+k] is valid after edge E(1+k), for k = 0..39.
  - w[43] is written at E40. At that edge `busy` goes to 0 and `key_ready` goes to 1.
  - Latency from start to ready is 40 cycles. The next `start` can be accepted at E40+1.
- `busy` and `key_ready` are registered, mutually exclusive, and never both high.
- `start` held high continuously:
  - One expansion runs.
  - After READY is reached, the next edge restarts the expansion, so `key_ready` pulses for one cycle.
- `start` coincident with reset release: ignored until `n_rst` has been high for one edge.

## Structure
- Package `aes_pkg` holds:
  - `typedef logic [31:0] word_t`
  - `localparam NUM_WORDS = 44`
  - the Rcon constant array
- The `encryption` block imports the same package.
- Sub-module `aes_sbox`: combinational 8-bit in/out S-box lookup.
  - Four instances form SubWord.
  - The same module is reused by the SubBytes stage in `encryption`.
- Top level contains the FSM, the 6-bit cnt, the 44x32 schedule register file, and the temp/XOR datapath.
- Rcon index = cnt[5:2].

## Test plan
- Reset with `n_rst`=0 → all words 0, `busy`=0, `key_ready`=0. Pulse `start` while in reset → no effect.
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse:
  - `key_ready` rises exactly 40 cycles after the start edge.
  - w[4]=a0fafe17, w[43]=b6630ca6.
- Key "lukeimyourfather" (6c756b65696d796f7572666174686572):
  - w[4]=28382bf7, w[8]=aee916fe, w[40]=04a2e8ef, w[43]=a4405979.
  - This schedule drives `encryption` in the existing bench.
- Assert `n_rst` at cycle 20 of an expansion:
  - Outputs clear asynchronously.
  - A new start then yields a correct FIPS-197 schedule.
- `start` pulsed again during EXPAND with a different key → ignored. The original schedule completes unchanged.
- From READY, start with the FIPS key, then the "luke" key:
  - `key_ready` drops one edge after start.
  - After 40 cycles the schedule matches the second key exactly.
